dmem_unit: RTL and testbench
============================

# dmem_unit

Parametrised data-memory unit for the single-cycle/multicycle core datapath: replaces the fixed 4 KiB word-only store with a sized, depth-configurable memory behind a valid/ready request port and a registered response. It supports byte, halfword and word accesses with byte write enables and signed or unsigned load extension. Out-of-range accesses are flagged rather than silently dropped. It sits between the core's memory stage and the load writeback mux.

## Interface
- `ADDR_W`, 32, byte-address width.
- `DEPTH_WORDS`, 1024, number of 32-bit words. Power of two, at least 4.
- `INIT_FILE`, "", hex file loaded with `$readmemh` when non-empty.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; a request is accepted on `req_valid && req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as error).
- `req_unsigned`  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-aligned (bits [7:0] for byte).
- `rsp_valid`  out  1  one-cycle pulse per accepted request, loads and stores alike.
- `rsp_rdata`  out  32  extended load data. 0 for stores and on error.
- `rsp_err`  out  1  qualifies `rsp_valid`; set on range, size or alignment error.

## Operation
- Storage: `DEPTH_WORDS` × 32 array with per-byte write enables. The word index is `req_addr >> 2`, and the byte lane is `req_addr[1:0]`.
- States: IDLE, SPLIT (macro only), RESP.
  - `req_ready` = 1 only in IDLE.
- In IDLE, accepting a request performs the access on the accept edge:
  - **Store:** writes the lanes selected by size and offset.
  - **Load:** captures the addressed word(s).
  - Next state is RESP, or SPLIT for a split access.
- In SPLIT, the access to word index + 1 happens on that edge, and the FSM then goes to RESP.
- In RESP, `rsp_valid` = 1 for exactly one cycle and the FSM returns to IDLE. There is no response backpressure.
- Range check: the access is out of range if any touched word index ≥ `DEPTH_WORDS`, or any address bit above the index is set. On a range error:
  - No byte is written, including the first half of a split.
  - `rsp_err` = 1 and `rsp_rdata` = 0.
- Alignment:
  - Half accesses need `addr[0]` = 0.
  - Word accesses need `addr[1:0]` = 00.
  - Handling of misaligned accesses is set by the macro (see Configuration).
- Load extension: the selected byte or half is shifted to bit 0 and extended per `req_unsigned`. For word loads, `req_unsigned` is ignored.
- Little-endian byte order throughout.

## Timing
- Reset values: state IDLE, `req_ready` = 1 after reset deasserts, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0. The array is not reset.
- Aligned or error access: accept at edge N, then `rsp_valid` is high during the cycle after edge N+1. That is 2-cycle latency and one request per 2 cycles.
- Split access: accept at edge N, second word at edge N+1, response in the cycle after edge N+2.
- `req_valid` while not ready is ignored. The requester must hold the request until it is accepted.
- Reset mid-operation returns to IDLE immediately and drops the pending response. A split store interrupted after its first edge leaves the first word written.
- Read-during-write: a load issued the cycle after a store to the same word returns the new data.

## Configuration
- `DMEM_MISALIGN_SPLIT_EN` defined:
  - Misaligned half/word accesses that stay within one word complete in a single access.
  - Accesses that cross a word boundary use the SPLIT state. Low bytes come from word k and high bytes from word k+1, in both directions.
  - `rsp_err` = 0 for these accesses.
- Undefined:
  - Any misaligned half/word access sets `rsp_err` = 1, performs no write, returns `rsp_rdata` = 0, and uses aligned latency.
  - The SPLIT state is not synthesised.

## Test plan
- **Word store and load.**
  - Stimulus: store word 0xDEADBEEF to 0x10, then load word from 0x10.
  - Response: `rsp_rdata` = 0xDEADBEEF, `rsp_err` = 0, `rsp_valid` two cycles after each accept.
- **Byte and halfword lanes with extension.**
  - Stimulus: after the first test, store byte 0x80 to 0x11.
  - Response: a signed byte load from 0x11 returns 0xFFFFFF80.
  - Response: an unsigned half load from 0x10 returns 0x000080EF.
  - Response: a word load from 0x10 returns 0xDEAD80EF.
- **Range error.**
  - Stimulus: with `DEPTH_WORDS` = 1024, store to 0x1000, then load from 0x1000.
  - Response: `rsp_err` = 1 on both accesses.
  - Response: word 0 is unchanged.
  - Response: the load returns 0.
- **Misaligned word at 0x13, macro off.**
  - Response: `rsp_err` = 1.
  - Response: words 4 and 5 are unchanged.
- **Misaligned word at 0x13, macro on.**
  - Stimulus: store 0x11223344 to 0x13.
  - Response: word 4 bits [31:24] = 0x44.
  - Response: word 5 bits [23:0] = 0x112233.
  - Response: a word load from 0x13 returns 0x11223344 with 3-cycle latency.
- **Reset mid-operation.**
  - Stimulus: assert `rst` in the RESP cycle.
  - Response: `rsp_valid` drops at once.
  - Response: `req_ready` = 1 after reset deasserts.
  - Response: no spurious response follows.

Source files
------------

// File: rtl/dmem_unit.sv
// dmem_unit: byte-addressable data memory behind a valid/ready request port.
// Define DMEM_MISALIGN_SPLIT_EN to serve misaligned accesses via a two-word split.
module dmem_unit #(
  parameter int    ADDR_W      = 32,
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    RESP
`ifdef DMEM_MISALIGN_SPLIT_EN
    , SPLIT
`endif
  } state_t;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic [3:0]       size_m;
  logic             size_bad;
  logic             hi_set;
  logic             acc_err;
  logic             acc;

  assign off      = req_addr[1:0];
  assign idx      = req_addr[IDX_W+1:2];
  assign size_bad = req_size == 2'b11;
  assign hi_set   = (req_addr >> (IDX_W + 2)) != '0;
  assign acc      = req_valid && req_ready && !rst;

  always_comb begin
    size_m = 4'b0000;
    unique case (req_size)
      2'b00:   size_m = 4'b0001;
      2'b01:   size_m = 4'b0011;
      2'b10:   size_m = 4'b1111;
      default: size_m = 4'b0000;
    endcase
  end

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic [7:0]       lane_m;
  logic [63:0]      lane_d;
  logic             cross;
  logic [31:0]      w1;
  logic [IDX_W-1:0] hi_idx;
  logic [3:0]       hi_m;
  logic [31:0]      hi_d;

  assign lane_m  = {4'b0000, size_m} << off;
  assign lane_d  = {32'd0, req_wdata} << {off, 3'b000};
  assign cross   = lane_m[7:4] != 4'b0000;
  // a split starting at the last word would wrap to word 0
  assign acc_err = size_bad || hi_set || (cross && (&idx));
`else
  logic [3:0]  lane_m;
  logic [31:0] lane_d;
  logic        misal;

  assign lane_m  = size_m << off;
  assign lane_d  = req_wdata << {off, 3'b000};
  assign misal   = (req_size == 2'b01 && off[0]) ||
                   (req_size == 2'b10 && off != 2'b00);
  assign acc_err = size_bad || misal || hi_set;
`endif

  state_t      state;
  logic [31:0] w0;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        err_q;
  logic        wr_q;
  logic [31:0] sh;
  logic [31:0] ext;

`ifdef DMEM_MISALIGN_SPLIT_EN
  assign sh = 32'({w1, w0} >> {off_q, 3'b000});
`else
  assign sh = w0 >> {off_q, 3'b000};
`endif

  always_comb begin
    ext = sh;
    unique case (size_q)
      2'b00:   ext = {{24{sh[7] & ~uns_q}}, sh[7:0]};
      2'b01:   ext = {{16{sh[15] & ~uns_q}}, sh[15:0]};
      default: ext = sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (acc && req_write && !acc_err) begin
      for (int b = 0; b < 4; b++)
        if (lane_m[b]) mem[idx][8*b +: 8] <= lane_d[8*b +: 8];
    end
`ifdef DMEM_MISALIGN_SPLIT_EN
    if (state == SPLIT && wr_q) begin
      for (int b = 0; b < 4; b++)
        if (hi_m[b]) mem[hi_idx][8*b +: 8] <= hi_d[8*b +: 8];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      w0        <= '0;
      off_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
      w1        <= '0;
      hi_idx    <= '0;
      hi_m      <= '0;
      hi_d      <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc) begin
            w0        <= mem[idx];
            off_q     <= off;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            err_q     <= acc_err;
            wr_q      <= req_write;
            req_ready <= 1'b0;
            state     <= RESP;
`ifdef DMEM_MISALIGN_SPLIT_EN
            hi_idx    <= idx + IDX_W'(1);
            hi_m      <= lane_m[7:4];
            hi_d      <= lane_d[63:32];
            if (cross && !acc_err) state <= SPLIT;
`endif
          end
        end
`ifdef DMEM_MISALIGN_SPLIT_EN
        SPLIT: begin
          w1    <= mem[hi_idx];
          state <= RESP;
        end
`endif
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err_q;
          rsp_rdata <= (err_q || wr_q) ? '0 : ext;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: directed vector table plus reset corner sequences.
// Expected values follow the macro setting the design is built with.
module tb_dmem_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_unit #(
    .ADDR_W(32),
    .DEPTH_WORDS(1024),
    .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;

  function automatic vec_t mk(logic wr, logic [1:0] sz, logic uns,
                              logic [31:0] a, logic [31:0] d,
                              logic [31:0] rd, logic er, int lat);
    vec_t v;
    v.wr = wr; v.sz = sz; v.uns = uns; v.addr = a; v.wd = d;
    v.exp_rd = rd; v.exp_err = er; v.exp_lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er,
                      output int lat);
    int n;
    req_valid = 1'b1; req_write = wr; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 8);
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        seen;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = W;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);

    tbl.push_back(mk(1, W, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2));
    tbl.push_back(mk(0, W, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2));
    tbl.push_back(mk(1, B, 0, 32'h11, 32'h80, 32'h0, 0, 2));
    tbl.push_back(mk(0, B, 0, 32'h11, 32'h0, 32'hFFFFFF80, 0, 2));
    tbl.push_back(mk(0, H, 1, 32'h10, 32'h0, 32'h000080EF, 0, 2));
    tbl.push_back(mk(0, W, 0, 32'h10, 32'h0, 32'hDEAD80EF, 0, 2));
    tbl.push_back(mk(0, H, 0, 32'h10, 32'h0, 32'hFFFF80EF, 0, 2));
    tbl.push_back(mk(0, B, 1, 32'h13, 32'h0, 32'h000000DE, 0, 2));
    tbl.push_back(mk(0, H, 0, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 2));
    tbl.push_back(mk(1, W, 0, 32'h0, 32'h01234567, 32'h0, 0, 2));
    tbl.push_back(mk(1, W, 0, 32'h1000, 32'hAAAAAAAA, 32'h0, 1, 2));
    tbl.push_back(mk(0, W, 0, 32'h1000, 32'h0, 32'h0, 1, 2));
    tbl.push_back(mk(0, W, 0, 32'h0, 32'h0, 32'h01234567, 0, 2));
    tbl.push_back(mk(1, B, 0, 32'h0, 32'hFFFFFF99, 32'h0, 0, 2));
    tbl.push_back(mk(0, W, 0, 32'h0, 32'h0, 32'h01234599, 0, 2));
    tbl.push_back(mk(1, H, 0, 32'h2, 32'h0000ABCD, 32'h0, 0, 2));
    tbl.push_back(mk(0, W, 0, 32'h0, 32'h0, 32'hABCD4599, 0, 2));
    tbl.push_back(mk(0, B, 0, 32'h2, 32'h0, 32'hFFFFFFCD, 0, 2));
    tbl.push_back(mk(1, W, 0, 32'h14, 32'h55667788, 32'h0, 0, 2));
    tbl.push_back(mk(0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 2));
    tbl.push_back(mk(0, W, 0, 32'h80000010, 32'h0, 32'h0, 1, 2));
    tbl.push_back(mk(1, W, 0, 32'hFFC, 32'hCAFEF00D, 32'h0, 0, 2));
    tbl.push_back(mk(1, W, 0, 32'hFFF, 32'h11111111, 32'h0, 1, 2));
    tbl.push_back(mk(0, W, 0, 32'hFFC, 32'h0, 32'hCAFEF00D, 0, 2));
`ifdef DMEM_MISALIGN_SPLIT_EN
    tbl.push_back(mk(1, W, 0, 32'h13, 32'h11223344, 32'h0, 0, 3));
    tbl.push_back(mk(0, W, 0, 32'h10, 32'h0, 32'h44AD80EF, 0, 2));
    tbl.push_back(mk(0, W, 0, 32'h14, 32'h0, 32'h55112233, 0, 2));
    tbl.push_back(mk(0, W, 0, 32'h13, 32'h0, 32'h11223344, 0, 3));
    tbl.push_back(mk(0, H, 1, 32'h11, 32'h0, 32'h0000AD80, 0, 2));
    tbl.push_back(mk(0, H, 0, 32'h13, 32'h0, 32'h00003344, 0, 3));
`else
    tbl.push_back(mk(1, W, 0, 32'h13, 32'h11223344, 32'h0, 1, 2));
    tbl.push_back(mk(0, W, 0, 32'h10, 32'h0, 32'hDEAD80EF, 0, 2));
    tbl.push_back(mk(0, W, 0, 32'h14, 32'h0, 32'h55667788, 0, 2));
    tbl.push_back(mk(0, W, 0, 32'h13, 32'h0, 32'h0, 1, 2));
    tbl.push_back(mk(0, H, 1, 32'h11, 32'h0, 32'h0, 1, 2));
    tbl.push_back(mk(1, H, 0, 32'h3, 32'hFFFF, 32'h0, 1, 2));
    tbl.push_back(mk(0, W, 0, 32'h0, 32'h0, 32'hABCD4599, 0, 2));
`endif

    foreach (tbl[i]) begin
      xfer(tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd,
           rd, er, lat);
      chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
      chk($sformatf("v%0d_lat", i), lat, tbl[i].exp_lat);
    end

    @(negedge clk);
    chk("pulse_one_cycle", {31'd0, rsp_valid}, 32'd0);

    // reset while the FSM sits in RESP
    req_valid = 1'b1; req_write = 1'b0; req_size = W; req_addr = 32'h10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("busy_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    #1 chk("rstA_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rstA_ready", {31'd0, req_ready}, 32'd1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("rstA_no_rsp", {31'd0, seen}, 32'd0);

    // reset while the response pulse is visible
    req_valid = 1'b1; req_write = 1'b0; req_size = W; req_addr = 32'h0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstB_pre_valid", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b1;
    #1 chk("rstB_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstB_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rstB_ready", {31'd0, req_ready}, 32'd1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("rstB_no_rsp", {31'd0, seen}, 32'd0);

    xfer(0, W, 0, 32'h14, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_SPLIT_EN
    chk("post_rst_rdata", rd, 32'h55112233);
`else
    chk("post_rst_rdata", rd, 32'h55667788);
`endif
    chk("post_rst_lat", lat, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
